dts_frame_gen: RTL and testbench
================================

# dts_frame_gen

Test-pattern transmitter for the DTS receive chain. Generates per-lane 128-bit frames with the `one_sec`, `ten_sec`, `index`, `sync` and `locked` sideband flags that the deframer normally produces, and drives `dts_reorder`/`dts_offsetter` inputs directly. Used in the receive-path benches and as a hardware loopback source when no antenna DTS link is present. One instance feeds one input lane.

## Interface
- `OUTPUT_DWIDTH`, 128: frame width in bits. Must be a multiple of 8.
- `FRAMES_PER_SEC`, 10000: frames per one-second epoch. Must be ≥ 2.
- `INDEX_PERIOD`, 16: frames between `index` markers. Must be ≥ 1.
- `LOCK_FRAMES`, 64: valid frames emitted before `dout_locked` rises. Must be ≥ 1.

Ports:
- `clk` in 1: single clock for all logic (gt_clkout domain).
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: emit a frame this cycle. Counters hold while low.
- `resync` in 1: pulse; restarts all counters at the next emitted frame.
- `pattern_sel` in 1: 0 = ramp, 1 = constant fill.
- `fill` in 8: fill byte used when `pattern_sel`=1.
- `dout` out OUTPUT_DWIDTH: frame payload.
- `dout_valid` out 1: `dout` and flags are valid.
- `dout_one_sec` out 1: first frame of a one-second epoch.
- `dout_ten_sec` out 1: first frame of a ten-second epoch.
- `dout_index` out 1: index marker.
- `dout_sync` out 1: first frame after reset or resync.
- `dout_locked` out 1: link-locked status.

## Operation
- **State:**
  - `frame_cnt` counts 0..FRAMES_PER_SEC-1.
  - `sec_cnt` counts 0..9.
  - `idx_cnt` counts 0..INDEX_PERIOD-1.
  - `base` is 8 bits.
  - `lock_cnt` saturates at LOCK_FRAMES.
  - `sync_pend` and `resync_pend` are 1-bit flags.
- **Reset:**
  - Clears all counters and `base`.
  - Sets `sync_pend`=1 and `resync_pend`=0.
  - Every output becomes 0.
- **Emitted frame (cycle with `en`=1, `rst`=0):** the outputs register the following from the current state.
  - `dout_valid`=1.
  - `dout_one_sec` = (`frame_cnt`==0).
  - `dout_ten_sec` = (`frame_cnt`==0 && `sec_cnt`==0).
  - `dout_index` = (`idx_cnt`==0).
  - `dout_sync` = `sync_pend`.
  - Ramp payload: byte lane b (bits 8b+7:8b) = (`base` + b) mod 256.
  - Fill payload: every byte = `fill`.
- **Counter advance after an emitted frame:**
  - `frame_cnt` wraps at FRAMES_PER_SEC-1 → 0. `sec_cnt` increments on that wrap and wraps 9 → 0.
  - `idx_cnt` wraps at INDEX_PERIOD-1 → 0.
  - `base` += OUTPUT_DWIDTH/8, mod 256.
  - `sync_pend` clears.
  - `lock_cnt` increments, saturating.
- **Idle cycle (`en`=0):**
  - `dout_valid` and all four event flags = 0.
  - `dout` holds its last value.
  - Counters hold.
- **Resync:**
  - `resync`=1 sets `resync_pend`.
  - On the next emitted frame with `resync_pend` set, the frame is emitted as counters = 0, `base` = 0 and `dout_sync`=1. `one_sec`, `ten_sec` and `index` are all 1 on that frame.
  - The counters then advance from 0 and `resync_pend` clears.
  - `resync` and `en` in the same cycle take effect on that same frame.
  - Resync does not affect `lock_cnt` or `dout_locked`.
- **Locked:** `dout_locked` = (`lock_cnt`==LOCK_FRAMES). It is sticky until `rst`.
- **Precedence:** `rst` overrides `en` and `resync` in the same cycle. A `resync` pulse arriving while `resync_pend` is already set is absorbed; there is no second restart.
- **Pattern changes:** `pattern_sel`/`fill` changes apply to the next emitted frame. There is no effect on counters or `base`, which advances in both modes.

## Timing
- Latency is one cycle: `en` sampled high at edge N produces the frame outputs after edge N.
- All outputs are registered; there is no combinational path from inputs to outputs.
- First `en` after `rst` deasserts gives a frame with `sync`, `one_sec`, `ten_sec` and `index` all high, `dout` = ramp with `base`=0.
- Continuous `en`:
  - `one_sec` every FRAMES_PER_SEC cycles.
  - `ten_sec` every 10·FRAMES_PER_SEC cycles.
  - `index` every INDEX_PERIOD cycles.
- `dout_locked` rises on the cycle the LOCK_FRAMES-th frame is emitted.
- `rst` asserted mid-stream: the next cycle has all outputs 0, and the sequence restarts exactly as from power-up.

## Test plan
Parameters for all scenarios: FRAMES_PER_SEC=8, INDEX_PERIOD=4, LOCK_FRAMES=3, OUTPUT_DWIDTH=128.

1. **Reset then continuous `en`:**
   - Frame 0: `sync`=`one_sec`=`ten_sec`=`index`=1, byte0=0x00, byte15=0x0F.
   - Frame 1: byte0=0x10.
   - `index` on frames 0,4,8,…; `one_sec` on 0,8,16,…; `ten_sec` on 0,80,160,….
   - `sync` only on frame 0.
2. **Lock and wrap:**
   - `dout_locked` low for frames 0–1, high from frame 2 onward and through a resync.
   - Frame 16: byte0 wraps to 0x00.
3. **`en` gaps:** alternate `en` 1/0 for 20 cycles.
   - `dout_valid` toggles.
   - Flags are 0 on idle cycles and `dout` holds.
   - The flag sequence over valid frames is identical to scenario 1.
4. **Resync:**
   - `resync` pulse with `en`=0 at frame 5, `en` resumes 3 cycles later.
   - The next frame has `sync`=`one_sec`=`ten_sec`=`index`=1 and byte0=0x00.
   - A second `resync` during the pending window is ignored.
5. **Fill mode:**
   - `pattern_sel`=1, `fill`=0xA5: all 16 bytes = 0xA5.
   - Switching back to ramp after 3 frames gives byte0 = 0x30 + previous ramp offset, showing `base` kept advancing.
6. **`rst` mid-stream with `en` and `resync` high:** next cycle all outputs are 0 and `dout_locked`=0, then the sequence is identical to scenario 1.

Source files
------------

// File: rtl/dts_frame_gen_if.sv
// Frame-generator bundle: lane control inputs plus the frame payload and sideband flags.
// The master drives the controls and the slave (the generator) drives the frame.
interface dts_frame_gen_if #(
    parameter int OUTPUT_DWIDTH = 128
) ();
    logic                     en;
    logic                     resync;
    logic                     pattern_sel;
    logic [7:0]               fill;
    logic [OUTPUT_DWIDTH-1:0] dout;
    logic                     dout_valid;
    logic                     dout_one_sec;
    logic                     dout_ten_sec;
    logic                     dout_index;
    logic                     dout_sync;
    logic                     dout_locked;

    modport master (
        output en, resync, pattern_sel, fill,
        input  dout, dout_valid, dout_one_sec, dout_ten_sec, dout_index, dout_sync, dout_locked
    );

    modport slave (
        input  en, resync, pattern_sel, fill,
        output dout, dout_valid, dout_one_sec, dout_ten_sec, dout_index, dout_sync, dout_locked
    );
endinterface

// File: rtl/dts_frame_gen.sv
// DTS test-pattern transmitter: one registered frame per enabled cycle, carrying the
// epoch/index/sync/locked sideband flags the deframer would normally produce.
module dts_frame_gen #(
    parameter int OUTPUT_DWIDTH  = 128,
    parameter int FRAMES_PER_SEC = 10000,
    parameter int INDEX_PERIOD   = 16,
    parameter int LOCK_FRAMES    = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    dts_frame_gen_if.slave   bus
);
    localparam int NBYTES = OUTPUT_DWIDTH / 8;
    localparam int FC_W   = $clog2(FRAMES_PER_SEC);
    localparam int IDX_W  = (INDEX_PERIOD > 1) ? $clog2(INDEX_PERIOD) : 1;
    localparam int LK_W   = $clog2(LOCK_FRAMES + 1);
    localparam logic [7:0]       BASE_STEP = 8'(NBYTES);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(FRAMES_PER_SEC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(INDEX_PERIOD - 1);
    localparam logic [LK_W-1:0]  LK_FULL   = LK_W'(LOCK_FRAMES);

    // Byte lane b of the ramp carries base + b, wrapping at 256.
    function automatic logic [OUTPUT_DWIDTH-1:0] ramp_payload(input logic [7:0] base);
        logic [OUTPUT_DWIDTH-1:0] v;
        v = '0;
        for (int b = 0; b < NBYTES; b++) begin
            v[8*b +: 8] = base + 8'(b);
        end
        return v;
    endfunction

    logic [FC_W-1:0]          r_frame_cnt;
    logic [3:0]               r_sec_cnt;
    logic [IDX_W-1:0]         r_idx_cnt;
    logic [7:0]               r_base;
    logic [LK_W-1:0]          r_lock_cnt;
    logic                     r_sync_pend;
    logic                     r_resync_pend;

    logic [OUTPUT_DWIDTH-1:0] r_dout;
    logic                     r_valid;
    logic                     r_one_sec;
    logic                     r_ten_sec;
    logic                     r_index;
    logic                     r_sync;
    logic                     r_locked;

    logic                     w_restart;
    logic [FC_W-1:0]          w_frame_cur;
    logic [3:0]               w_sec_cur;
    logic [IDX_W-1:0]         w_idx_cur;
    logic [7:0]               w_base_cur;
    logic                     w_sync_cur;
    logic [FC_W-1:0]          w_frame_nxt;
    logic [3:0]               w_sec_nxt;
    logic [IDX_W-1:0]         w_idx_nxt;
    logic [LK_W-1:0]          w_lock_nxt;
    logic [OUTPUT_DWIDTH-1:0] w_payload;

    // Effective counter values for this frame: a pending or same-cycle resync emits as if all were zero.
    always_comb begin
        w_restart = bus.resync | r_resync_pend;
        if (w_restart) begin
            w_frame_cur = '0;
            w_sec_cur   = 4'd0;
            w_idx_cur   = '0;
            w_base_cur  = 8'd0;
        end else begin
            w_frame_cur = r_frame_cnt;
            w_sec_cur   = r_sec_cnt;
            w_idx_cur   = r_idx_cnt;
            w_base_cur  = r_base;
        end
        w_sync_cur = r_sync_pend | w_restart;
    end

    // Successor counter values, applied only when a frame is emitted.
    always_comb begin
        w_frame_nxt = '0;
        w_sec_nxt   = w_sec_cur;
        if (w_frame_cur == FC_LAST) begin
            w_frame_nxt = '0;
            if (w_sec_cur == 4'd9) begin
                w_sec_nxt = 4'd0;
            end else begin
                w_sec_nxt = w_sec_cur + 4'd1;
            end
        end else begin
            w_frame_nxt = w_frame_cur + FC_W'(1);
            w_sec_nxt   = w_sec_cur;
        end

        if (w_idx_cur == IDX_LAST) begin
            w_idx_nxt = '0;
        end else begin
            w_idx_nxt = w_idx_cur + IDX_W'(1);
        end

        if (r_lock_cnt == LK_FULL) begin
            w_lock_nxt = r_lock_cnt;
        end else begin
            w_lock_nxt = r_lock_cnt + LK_W'(1);
        end
    end

    // Payload selection; the ramp base advances in both modes so ramp resumes in phase.
    always_comb begin
        w_payload = '0;
        case (bus.pattern_sel)
            1'b0:    w_payload = ramp_payload(w_base_cur);
            1'b1:    w_payload = {NBYTES{bus.fill}};
            default: w_payload = ramp_payload(w_base_cur);
        endcase
    end

    // Frame state, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_cnt   <= '0;
            r_sec_cnt     <= 4'd0;
            r_idx_cnt     <= '0;
            r_base        <= 8'd0;
            r_lock_cnt    <= '0;
            r_sync_pend   <= 1'b1;
            r_resync_pend <= 1'b0;
            r_dout        <= '0;
            r_valid       <= 1'b0;
            r_one_sec     <= 1'b0;
            r_ten_sec     <= 1'b0;
            r_index       <= 1'b0;
            r_sync        <= 1'b0;
            r_locked      <= 1'b0;
        end else if (bus.en) begin
            r_dout        <= w_payload;
            r_valid       <= 1'b1;
            r_one_sec     <= (w_frame_cur == '0);
            r_ten_sec     <= (w_frame_cur == '0) && (w_sec_cur == 4'd0);
            r_index       <= (w_idx_cur == '0);
            r_sync        <= w_sync_cur;
            r_locked      <= (w_lock_nxt == LK_FULL);
            r_frame_cnt   <= w_frame_nxt;
            r_sec_cnt     <= w_sec_nxt;
            r_idx_cnt     <= w_idx_nxt;
            r_base        <= w_base_cur + BASE_STEP;
            r_lock_cnt    <= w_lock_nxt;
            r_sync_pend   <= 1'b0;
            r_resync_pend <= 1'b0;
        end else begin
            r_valid       <= 1'b0;
            r_one_sec     <= 1'b0;
            r_ten_sec     <= 1'b0;
            r_index       <= 1'b0;
            r_sync        <= 1'b0;
            if (bus.resync) begin
                r_resync_pend <= 1'b1;
            end
        end
    end

    assign bus.dout         = r_dout;
    assign bus.dout_valid   = r_valid;
    assign bus.dout_one_sec = r_one_sec;
    assign bus.dout_ten_sec = r_ten_sec;
    assign bus.dout_index   = r_index;
    assign bus.dout_sync    = r_sync;
    assign bus.dout_locked  = r_locked;
endmodule

// File: tb/tb_dts_frame_gen.sv
// Directed bench for dts_frame_gen: a frame-number model predicts every output each cycle,
// and literal expectations pin the model at the notable frames.
module tb_dts_frame_gen;
    localparam int DW   = 128;
    localparam int FPS  = 8;
    localparam int IP   = 4;
    localparam int LOCK = 3;
    localparam int NB   = DW / 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    dts_frame_gen_if #(.OUTPUT_DWIDTH(DW)) u_if ();

    dts_frame_gen #(
        .OUTPUT_DWIDTH (DW),
        .FRAMES_PER_SEC(FPS),
        .INDEX_PERIOD  (IP),
        .LOCK_FRAMES   (LOCK)
    ) u_dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: frames since last (re)start, frames since reset, pending resync.
    int             m_n;
    int             m_total;
    bit             m_pend;
    logic [DW-1:0]  e_dout;
    logic           e_valid, e_one, e_ten, e_idx, e_sync, e_lock;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic rs, input logic ps, input logic [7:0] f);
        if (r) begin
            m_n = 0; m_total = 0; m_pend = 1'b0;
            e_dout = '0; e_valid = 0; e_one = 0; e_ten = 0; e_idx = 0; e_sync = 0; e_lock = 0;
        end else if (e) begin
            if (rs || m_pend) m_n = 0;
            e_valid = 1'b1;
            e_one   = (m_n % FPS) == 0;
            e_ten   = (m_n % (10 * FPS)) == 0;
            e_idx   = (m_n % IP) == 0;
            e_sync  = (m_n == 0);
            for (int b = 0; b < NB; b++) begin
                e_dout[8*b +: 8] = ps ? f : 8'((NB * m_n + b) % 256);
            end
            m_total++;
            e_lock  = (m_total >= LOCK);
            m_n++;
            m_pend  = 1'b0;
        end else begin
            e_valid = 0; e_one = 0; e_ten = 0; e_idx = 0; e_sync = 0;
            if (rs) m_pend = 1'b1;
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output after the edge.
    task automatic step(input logic r, input logic e, input logic rs, input logic ps, input logic [7:0] f);
        rst = r; u_if.en = e; u_if.resync = rs; u_if.pattern_sel = ps; u_if.fill = f;
        model(r, e, rs, ps, f);
        @(posedge clk);
        #1;
        chk("valid",   DW'(u_if.dout_valid),   DW'(e_valid));
        chk("one_sec", DW'(u_if.dout_one_sec), DW'(e_one));
        chk("ten_sec", DW'(u_if.dout_ten_sec), DW'(e_ten));
        chk("index",   DW'(u_if.dout_index),   DW'(e_idx));
        chk("sync",    DW'(u_if.dout_sync),    DW'(e_sync));
        chk("locked",  DW'(u_if.dout_locked),  DW'(e_lock));
        chk("dout",    u_if.dout,              e_dout);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; u_if.en = 1'b0; u_if.resync = 1'b0; u_if.pattern_sel = 1'b0; u_if.fill = 8'h00;
        @(posedge clk);
        #1;

        // Scenario 1 and 2: reset state, continuous en, lock and base wrap.
        do_reset();
        chk("rst_dout",   u_if.dout, '0);
        chk("rst_locked", DW'(u_if.dout_locked), DW'(1'b0));
        for (int k = 0; k <= 160; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            if (k == 0) begin
                chk("f0_flags", DW'({u_if.dout_sync, u_if.dout_one_sec, u_if.dout_ten_sec, u_if.dout_index}), DW'(4'hF));
                chk("f0_b0",    DW'(u_if.dout[7:0]),     DW'(8'h00));
                chk("f0_b15",   DW'(u_if.dout[127:120]), DW'(8'h0F));
                chk("f0_lock",  DW'(u_if.dout_locked),   DW'(1'b0));
            end
            if (k == 1) begin
                chk("f1_b0",   DW'(u_if.dout[7:0]),   DW'(8'h10));
                chk("f1_lock", DW'(u_if.dout_locked), DW'(1'b0));
                chk("f1_sync", DW'(u_if.dout_sync),   DW'(1'b0));
            end
            if (k == 2)  chk("f2_lock", DW'(u_if.dout_locked), DW'(1'b1));
            if (k == 16) chk("f16_b0",  DW'(u_if.dout[7:0]),   DW'(8'h00));
            if (k == 80) chk("f80_ten", DW'(u_if.dout_ten_sec), DW'(1'b1));
            if (k == 72) chk("f72_ten", DW'({u_if.dout_one_sec, u_if.dout_ten_sec}), DW'(2'b10));
        end

        // Scenario 3: en gaps.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(1'b0, (c % 2) == 0, 1'b0, 1'b0, 8'h00);
            if (c == 3) chk("gap_hold", DW'(u_if.dout[7:0]), DW'(8'h10));
        end

        // Scenario 4: resync while idle, a second absorbed resync, then same-cycle resync.
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("rs_flags", DW'({u_if.dout_sync, u_if.dout_one_sec, u_if.dout_ten_sec, u_if.dout_index}), DW'(4'hF));
        chk("rs_b0",    DW'(u_if.dout[7:0]),   DW'(8'h00));
        chk("rs_lock",  DW'(u_if.dout_locked), DW'(1'b1));
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("rs_next_b0",   DW'(u_if.dout[7:0]), DW'(8'h10));
        chk("rs_next_sync", DW'(u_if.dout_sync), DW'(1'b0));
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("rs_same_sync", DW'(u_if.dout_sync), DW'(1'b1));
        chk("rs_same_b0",   DW'(u_if.dout[7:0]), DW'(8'h00));
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Scenario 5: fill mode, then ramp resumes with base advanced through the fill frames.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
        chk("fill_all", u_if.dout, {NB{8'hA5}});
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("ramp_resume_b0", DW'(u_if.dout[7:0]), DW'(8'h50));

        // Scenario 6: reset mid-stream with en and resync high.
        do_reset();
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("mid_rst_dout",  u_if.dout, '0);
        chk("mid_rst_lock",  DW'(u_if.dout_locked), DW'(1'b0));
        chk("mid_rst_valid", DW'(u_if.dout_valid),  DW'(1'b0));
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            if (k == 0) chk("mid_f0_flags", DW'({u_if.dout_sync, u_if.dout_one_sec, u_if.dout_ten_sec, u_if.dout_index}), DW'(4'hF));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
